// File: rtl/bank_row_mapper.sv
// -----------------------------------------------------------------------------
// bank_row_mapper
//
// Purpose:
//   Maps wide device row addresses onto a small modeled bank storage array.
//   The bank array has CHROWS row slots. A fully associative table
//   {valid, tag} records which device row lives in which slot.
//
//   ACT (bank idle) picks a slot in this order:
//     - the slot already tagged with the row (hit);
//     - otherwise the lowest free slot;
//     - otherwise the slot at a round-robin victim pointer.
//   RD/WR (row open) then play out a BL-beat burst. The column wraps
//   inside the aligned BL block, so the array sees one column per beat.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   cmd_valid     a command is presented
//   cmd           0=ACT, 1=RD, 2=WR, 3=PRE
//   cmd_row       device row (ACT only)
//   cmd_col       start column (RD/WR only)
//   cmd_ready     command accepted this cycle when high
//                 (combinational from the FSM state)
//   row           slot index for the bank array (registered)
//   column        column for the bank array (registered)
//   rd_o_wr       array write strobe: 0=read, 1=write (registered)
//   burst_active  current cycle is a data beat (registered)
//   map_full      every slot holds a valid mapping (registered)
//   err           sticky illegal-command flag (registered)
// -----------------------------------------------------------------------------
module bank_row_mapper #(
    parameter int RAWIDTH  = 16,
    parameter int COLWIDTH = 10,
    parameter int CHWIDTH  = 5,
    parameter int BL       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    input  logic [RAWIDTH-1:0]  cmd_row,
    input  logic [COLWIDTH-1:0] cmd_col,
    output logic                cmd_ready,
    output logic [CHWIDTH-1:0]  row,
    output logic [COLWIDTH-1:0] column,
    output logic                rd_o_wr,
    output logic                burst_active,
    output logic                map_full,
    output logic                err
);

    localparam int CHROWS = 2 ** CHWIDTH;
    localparam int LBL    = $clog2(BL);

    // Low column bits that advance within a burst. The bits above them stay
    // fixed, which gives the wrap inside the aligned BL block.
    localparam logic [COLWIDTH-1:0] LOW_MASK  = COLWIDTH'(BL - 1);
    localparam logic [LBL-1:0]      LAST_BEAT = LBL'(BL - 1);

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_PRE = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_r;
    logic [CHROWS-1:0]    valid_r;
    logic [RAWIDTH-1:0]   tag_r [CHROWS];
    logic [CHWIDTH-1:0]   victim_r;
    logic [LBL-1:0]       beat_r;
    logic [CHWIDTH-1:0]   row_r;
    logic [COLWIDTH-1:0]  column_r;
    logic                 rd_o_wr_r;
    logic                 burst_active_r;
    logic                 map_full_r;
    logic                 err_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                 accept_s;
    logic                 act_idle_s;
    logic                 hit_s;
    logic [CHWIDTH-1:0]   hit_idx_s;
    logic                 free_s;
    logic [CHWIDTH-1:0]   free_idx_s;
    logic [CHWIDTH-1:0]   sel_idx_s;
    logic                 tbl_we_s;
    logic                 victim_adv_s;
    logic [COLWIDTH-1:0]  next_col_s;

    // Ready depends on the FSM state only, so a refused command costs
    // nothing and there is no path from cmd_valid to cmd_ready.
    assign cmd_ready  = (state_r != ST_BURST);
    assign accept_s   = cmd_valid & cmd_ready;
    assign act_idle_s = accept_s & (cmd == CMD_ACT) & (state_r == ST_IDLE);

    // Next beat's column: advance the low LBL bits, keep the block base bits.
    assign next_col_s = (column_r & ~LOW_MASK) | ((column_r + COLWIDTH'(1)) & LOW_MASK);

    // Associative lookup of cmd_row and search for a free slot.
    // The loop scans downwards, so the lowest matching index is written last
    // and wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (valid_r[i] && (tag_r[i] == cmd_row)) begin
                hit_s     = 1'b1;
                hit_idx_s = CHWIDTH'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
            if (!valid_r[i]) begin
                free_s     = 1'b1;
                free_idx_s = CHWIDTH'(i);
            end else begin
                free_s     = free_s;
                free_idx_s = free_idx_s;
            end
        end
    end

    // Slot choice for an ACT taken in IDLE: hit, then free slot, then victim.
    always_comb begin
        sel_idx_s    = victim_r;
        tbl_we_s     = 1'b0;
        victim_adv_s = 1'b0;
        if (hit_s) begin
            sel_idx_s = hit_idx_s;
        end else if (free_s) begin
            sel_idx_s = free_idx_s;
            tbl_we_s  = act_idle_s;
        end else begin
            sel_idx_s    = victim_r;
            tbl_we_s     = act_idle_s;
            victim_adv_s = act_idle_s;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Tag storage. It needs no reset because valid_r qualifies every entry.
    always_ff @(posedge clk) begin
        if (rst_n && tbl_we_s) begin
            tag_r[sel_idx_s] <= cmd_row;
        end else begin
            tag_r[sel_idx_s] <= tag_r[sel_idx_s];
        end
    end

    // FSM, valid bits, victim pointer, burst sequencing and all registered
    // outputs. The asynchronous reset aborts any burst in progress at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            valid_r        <= '0;
            victim_r       <= '0;
            beat_r         <= '0;
            row_r          <= '0;
            column_r       <= '0;
            rd_o_wr_r      <= 1'b0;
            burst_active_r <= 1'b0;
            map_full_r     <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            // Samples the valid bits one edge after any table write.
            map_full_r <= &valid_r;

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (cmd)
                            CMD_ACT: begin
                                row_r   <= sel_idx_s;
                                state_r <= ST_OPEN;
                                if (tbl_we_s) begin
                                    valid_r[sel_idx_s] <= 1'b1;
                                end else begin
                                    valid_r <= valid_r;
                                end
                                if (victim_adv_s) begin
                                    victim_r <= victim_r + CHWIDTH'(1);
                                end else begin
                                    victim_r <= victim_r;
                                end
                            end
                            CMD_RD, CMD_WR: begin
                                // No row is open, so the data command is dropped.
                                err_r <= 1'b1;
                            end
                            CMD_PRE: begin
                                // Already precharged, so nothing changes.
                                state_r <= ST_IDLE;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_OPEN: begin
                    if (accept_s) begin
                        case (cmd)
                            CMD_ACT: begin
                                // A row is already open, so the ACT is dropped.
                                err_r <= 1'b1;
                            end
                            CMD_RD, CMD_WR: begin
                                // Beat 0 is presented in the cycle after acceptance.
                                state_r        <= ST_BURST;
                                beat_r         <= '0;
                                column_r       <= cmd_col;
                                rd_o_wr_r      <= (cmd == CMD_WR);
                                burst_active_r <= 1'b1;
                            end
                            CMD_PRE: begin
                                state_r <= ST_IDLE;
                            end
                            default: begin
                                state_r <= ST_OPEN;
                            end
                        endcase
                    end else begin
                        state_r <= ST_OPEN;
                    end
                end

                ST_BURST: begin
                    if (beat_r == LAST_BEAT) begin
                        // Leave the column on its final beat value.
                        state_r        <= ST_OPEN;
                        rd_o_wr_r      <= 1'b0;
                        burst_active_r <= 1'b0;
                    end else begin
                        beat_r   <= beat_r + LBL'(1);
                        column_r <= next_col_s;
                    end
                end

                default: begin
                    state_r        <= ST_IDLE;
                    rd_o_wr_r      <= 1'b0;
                    burst_active_r <= 1'b0;
                end
            endcase
        end
    end

    assign row          = row_r;
    assign column       = column_r;
    assign rd_o_wr      = rd_o_wr_r;
    assign burst_active = burst_active_r;
    assign map_full     = map_full_r;
    assign err          = err_r;

endmodule

// File: tb/tb_bank_row_mapper.sv
// -----------------------------------------------------------------------------
// tb_bank_row_mapper
//
// Directed bench for bank_row_mapper with default parameters
// (RAWIDTH=16, COLWIDTH=10, CHWIDTH=5, BL=8).
//
// A table of single-cycle vectors covers:
//   - map reuse;
//   - read and write bursts with column wrap;
//   - commands offered during a burst;
//   - illegal commands.
// Each vector holds the inputs and the outputs expected after one edge.
//
// Hand-written sequences then cover eviction with map_full timing, and a
// reset asserted in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_bank_row_mapper;

    localparam logic [1:0] ACT = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] WR  = 2'd2;
    localparam logic [1:0] PRE = 2'd3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd       = 2'd0;
    logic [15:0] cmd_row   = 16'd0;
    logic [9:0]  cmd_col   = 10'd0;
    logic        cmd_ready;
    logic [4:0]  row;
    logic [9:0]  column;
    logic        rd_o_wr;
    logic        burst_active;
    logic        map_full;
    logic        err;

    bank_row_mapper #(
        .RAWIDTH (16),
        .COLWIDTH(10),
        .CHWIDTH (5),
        .BL      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_ready   (cmd_ready),
        .row         (row),
        .column      (column),
        .rd_o_wr     (rd_o_wr),
        .burst_active(burst_active),
        .map_full    (map_full),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        v;
        logic [1:0]  c;
        logic [15:0] r;
        logic [9:0]  col;
        logic        e_rdy;
        logic [4:0]  e_row;
        logic [9:0]  e_col;
        logic        e_bst;
        logic        e_wr;
        logic        e_full;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic [4:0] e_row,
                             input logic [9:0] e_col, input logic e_bst, input logic e_wr,
                             input logic e_full, input logic e_err);
        check({tag, " cmd_ready"},    32'(cmd_ready),    32'(e_rdy));
        check({tag, " row"},          32'(row),          32'(e_row));
        check({tag, " column"},       32'(column),       32'(e_col));
        check({tag, " burst_active"}, 32'(burst_active), 32'(e_bst));
        check({tag, " rd_o_wr"},      32'(rd_o_wr),      32'(e_wr));
        check({tag, " map_full"},     32'(map_full),     32'(e_full));
        check({tag, " err"},          32'(err),          32'(e_err));
    endtask

    task automatic add(input logic v, input logic [1:0] c, input logic [15:0] r,
                       input logic [9:0] col, input logic e_rdy, input logic [4:0] e_row,
                       input logic [9:0] e_col, input logic e_bst, input logic e_wr,
                       input logic e_full, input logic e_err);
        vec_t t;
        t.v = v; t.c = c; t.r = r; t.col = col;
        t.e_rdy = e_rdy; t.e_row = e_row; t.e_col = e_col; t.e_bst = e_bst;
        t.e_wr = e_wr; t.e_full = e_full; t.e_err = e_err;
        vecs.push_back(t);
    endtask

    // Drive one command at the falling edge, then sample just after the rising edge.
    task automatic apply(input logic v, input logic [1:0] c, input logic [15:0] r,
                         input logic [9:0] col);
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        cmd_row   = r;
        cmd_col   = col;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_all(tag, 1'b1, 5'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        //   v     cmd  row        col        rdy   row   col        bst   wr    full  err
        add(1'b1, ACT, 16'h1234, 10'h000, 1'b1, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, PRE, 16'h0000, 10'h000, 1'b1, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, ACT, 16'h0042, 10'h000, 1'b1, 5'd1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, PRE, 16'h0000, 10'h000, 1'b1, 5'd1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, ACT, 16'h1234, 10'h000, 1'b1, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        // RD at 0x3FE: wraps inside the 0x3F8 block; a command offered mid-burst is ignored
        add(1'b1, RD,  16'h0000, 10'h3FE, 1'b0, 5'd0, 10'h3FE, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, ACT, 16'h5555, 10'h000, 1'b0, 5'd0, 10'h3F8, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3F9, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3FA, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3FB, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3FC, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h3FD, 1'b1, 1'b0, 1'b0, 1'b0);
        // invalid PRE: bank must stay open
        add(1'b0, PRE, 16'h0000, 10'h000, 1'b1, 5'd0, 10'h3FD, 1'b0, 1'b0, 1'b0, 1'b0);
        // WR at 0x00D
        add(1'b1, WR,  16'h0000, 10'h00D, 1'b0, 5'd0, 10'h00D, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h00E, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h00F, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h008, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h009, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h00A, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h00B, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd0, 10'h00C, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b1, 5'd0, 10'h00C, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, PRE, 16'h0000, 10'h000, 1'b1, 5'd0, 10'h00C, 1'b0, 1'b0, 1'b0, 1'b0);
        // PRE in IDLE: no-op, no err
        add(1'b1, PRE, 16'h0000, 10'h000, 1'b1, 5'd0, 10'h00C, 1'b0, 1'b0, 1'b0, 1'b0);
        // RD in IDLE: err, no burst
        add(1'b1, RD,  16'h0000, 10'h010, 1'b1, 5'd0, 10'h00C, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, ACT, 16'h0042, 10'h000, 1'b1, 5'd1, 10'h00C, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, RD,  16'h0000, 10'h007, 1'b0, 5'd1, 10'h007, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h001, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h002, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h003, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h004, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h005, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h006, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b1, 5'd1, 10'h006, 1'b0, 1'b0, 1'b0, 1'b1);
        // ACT while OPEN: dropped, row unchanged; a following WR still works
        add(1'b1, ACT, 16'h5555, 10'h000, 1'b1, 5'd1, 10'h006, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, WR,  16'h0000, 10'h3F0, 1'b0, 5'd1, 10'h3F0, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F1, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F2, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F3, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F4, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F5, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F6, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b0, 5'd1, 10'h3F7, 1'b1, 1'b1, 1'b0, 1'b1);
        add(1'b0, ACT, 16'h0000, 10'h000, 1'b1, 5'd1, 10'h3F7, 1'b0, 1'b0, 1'b0, 1'b1);

        apply_reset("reset0");
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].v, vecs[i].c, vecs[i].r, vecs[i].col);
            check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_row, vecs[i].e_col,
                      vecs[i].e_bst, vecs[i].e_wr, vecs[i].e_full, vecs[i].e_err);
        end

        // ---------------- eviction and map_full timing ----------------
        apply_reset("reset1");
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, ACT, 16'h1000 + 16'(i), 10'h000);
            check($sformatf("evict act%0d row", i), 32'(row), 32'(i));
            check($sformatf("evict act%0d map_full", i), 32'(map_full), 32'd0);
            apply(1'b1, PRE, 16'h0000, 10'h000);
            check($sformatf("evict pre%0d map_full", i), 32'(map_full), (i == 31) ? 32'd1 : 32'd0);
        end
        apply(1'b1, ACT, 16'h2000, 10'h000);
        check("evict new33 row", 32'(row), 32'd0);
        check("evict new33 map_full", 32'(map_full), 32'd1);
        apply(1'b1, PRE, 16'h0000, 10'h000);
        apply(1'b1, ACT, 16'h2001, 10'h000);
        check("evict new34 row", 32'(row), 32'd1);
        apply(1'b1, PRE, 16'h0000, 10'h000);
        apply(1'b1, ACT, 16'h1002, 10'h000);
        check("evict old hit row", 32'(row), 32'd2);
        apply(1'b1, PRE, 16'h0000, 10'h000);
        apply(1'b1, ACT, 16'h2000, 10'h000);
        check("evict new33 hit row", 32'(row), 32'd0);
        apply(1'b1, PRE, 16'h0000, 10'h000);
        apply(1'b1, ACT, 16'h2002, 10'h000);
        check("evict new35 row", 32'(row), 32'd2);
        check("evict err", 32'(err), 32'd0);

        // ---------------- reset in the middle of a burst ----------------
        apply_reset("reset2");
        apply(1'b1, ACT, 16'h0100, 10'h000);
        check("mid pre-row slot", 32'(row), 32'd0);
        apply(1'b1, PRE, 16'h0000, 10'h000);
        apply(1'b1, ACT, 16'h0777, 10'h000);
        check("mid row slot", 32'(row), 32'd1);
        apply(1'b1, WR, 16'h0000, 10'h020);
        check("mid beat0 col", 32'(column), 32'h020);
        apply(1'b0, ACT, 16'h0000, 10'h000);
        apply(1'b0, ACT, 16'h0000, 10'h000);
        apply(1'b0, ACT, 16'h0000, 10'h000);
        check("mid beat3 col", 32'(column), 32'h023);
        check("mid beat3 wr", 32'(rd_o_wr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid in-reset", 1'b1, 5'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mid held burst_active", 32'(burst_active), 32'd0);
        check("mid held rd_o_wr", 32'(rd_o_wr), 32'd0);
        // Release and present ACT together: it must be taken on the first edge.
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd       = ACT;
        cmd_row   = 16'h0777;
        @(posedge clk);
        #1;
        check_all("mid after-release", 1'b1, 5'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, RD, 16'h0000, 10'h005);
        check("mid post rd burst", 32'(burst_active), 32'd1);
        check("mid post rd col", 32'(column), 32'h005);
        @(negedge clk);
        cmd_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
